// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: two-flop sync, stability counter,
// press/release strobes and per-channel auto-repeat.
module button_debouncer_ch #(
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);
  localparam int SW   = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX < 2) ? 1 : $clog2(RMAX);

  typedef enum logic [1:0] {IDLE, HELD, REPEATING} state_e;

  logic          sync1_q, sample_q;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          pressed_q, pressed_d;
  logic [RW-1:0] rcnt_q;
  state_e        state_q;
  logic          press_q, rel_q, rpt_q;
  logic          differ, accept, accept_press, accept_release, rpt_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sample_q <= 1'b1;
    end else begin
      sync1_q  <= btn_n;
      sample_q <= sync1_q;
    end
  end

  // sample is active-low; it "differs" when its level disagrees with the debounced state
  assign differ         = (~sample_q) != pressed_q;
  assign accept         = differ && (scnt_q == SW'(STABLE_CYCLES - 1));
  assign accept_press   = accept && !pressed_q;
  assign accept_release = accept && pressed_q;

  always_comb begin
    scnt_d    = scnt_q + 1'b1;
    pressed_d = pressed_q;
    if (!differ || accept) scnt_d = '0;
    if (accept) pressed_d = ~pressed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q    <= '0;
      pressed_q <= 1'b0;
    end else begin
      scnt_q    <= scnt_d;
      pressed_q <= pressed_d;
    end
  end

  // With REPEAT_RATE == 0 the channel parks in HELD and never fires a repeat
  assign rpt_hit = (REPEAT_RATE != 0) &&
                   (((state_q == HELD)      && (rcnt_q == RW'(REPEAT_DELAY - 1))) ||
                    ((state_q == REPEATING) && (rcnt_q == RW'(REPEAT_RATE - 1))));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      press_q <= accept_press;
      rel_q   <= accept_release;
      rpt_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          rcnt_q <= '0;
          if (accept_press) state_q <= HELD;
        end
        HELD, REPEATING: begin
          // release wins over a coinciding repeat slot
          if (accept_release) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
          end else if (rpt_hit) begin
            rpt_q   <= 1'b1;
            rcnt_q  <= '0;
            state_q <= REPEATING;
          end else if (REPEAT_RATE != 0) begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          rcnt_q  <= '0;
        end
      endcase
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign repeat_pulse  = rpt_q;
endmodule

module button_debouncer #(
  parameter int NUM_BUTTONS   = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_n,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] repeat_pulse,
  output logic                   any_pressed
);
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_debouncer_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .btn_n        (btn_n[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

  assign any_pressed = |pressed;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer; a second instance runs with auto-repeat disabled.
module tb_button_debouncer;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] pr, pp, rp, rr;
  logic          anyp;
  logic [NB-1:0] pr0, pp0, rp0, rr0;
  logic          anyp0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  button_debouncer #(.NUM_BUTTONS(NB), .STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .pressed(pr), .press_pulse(pp),
    .release_pulse(rp), .repeat_pulse(rr), .any_pressed(anyp));

  button_debouncer #(.NUM_BUTTONS(NB), .STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(0)) dut0 (
    .clk(clk), .rst(rst), .btn_n(btn_n), .pressed(pr0), .press_pulse(pp0),
    .release_pulse(rp0), .repeat_pulse(rr0), .any_pressed(anyp0));

  // observation vector: {pressed, press_pulse, release_pulse, repeat_pulse, any_pressed}
  task automatic test_reset();
    logic [16:0] obs, exp;
    rst = 1'b1;
    btn_n = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      obs = {pr, pp, rp, rr, anyp};
      exp = '0;
      n_chk++;
      if (obs !== exp) $display("FAIL reset k=%0d got %h want %h", k, obs, exp);
      else n_pass++;
    end
    btn_n = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_press();
    logic [16:0] obs, exp;
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      obs = {pr, pp, rp, rr, anyp};
      exp = {(k >= 6) ? 4'b0001 : 4'b0000, (k == 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, k >= 6};
      n_chk++;
      if (obs !== exp) $display("FAIL press k=%0d got %h want %h", k, obs, exp);
      else n_pass++;
    end
    btn_n[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      obs = {pr, pp, rp, rr, anyp};
      exp = {(k < 6) ? 4'b0001 : 4'b0000, 4'b0000, (k == 6) ? 4'b0001 : 4'b0000, 4'b0000, k < 6};
      n_chk++;
      if (obs !== exp) $display("FAIL release k=%0d got %h want %h", k, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [16:0] obs;
    btn_n[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      obs = {pr, pp, rp, rr, anyp};
      n_chk++;
      if (obs !== 17'h0) $display("FAIL bounce k=%0d got %h want %h", k, obs, 17'h0);
      else n_pass++;
      if (k == 3) btn_n[1] = 1'b1;
      if (k == 4) btn_n[1] = 1'b0;
      if (k == 7) btn_n[1] = 1'b1;
    end
  endtask

  task automatic test_simultaneous();
    logic [16:0] obs, exp;
    btn_n = 4'b0110;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      obs = {pr, pp, rp, rr, anyp};
      exp = {(k >= 6) ? 4'b1001 : 4'b0000, (k == 6) ? 4'b1001 : 4'b0000, 4'b0000, 4'b0000, k >= 6};
      n_chk++;
      if (obs !== exp) $display("FAIL simul_press k=%0d got %h want %h", k, obs, exp);
      else n_pass++;
    end
    btn_n = 4'b1111;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      obs = {pr, pp, rp, rr, anyp};
      exp = {(k < 6) ? 4'b1001 : 4'b0000, 4'b0000, (k == 6) ? 4'b1001 : 4'b0000, 4'b0000, k < 6};
      n_chk++;
      if (obs !== exp) $display("FAIL simul_release k=%0d got %h want %h", k, obs, exp);
      else n_pass++;
    end
  endtask

  // press lands at k=6; released so that the release strobe (k=43) falls on a repeat slot
  task automatic test_repeat();
    logic [16:0] obs, exp, obs0, exp0;
    logic        held, rpt;
    btn_n[2] = 1'b0;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      held = (k >= 6) && (k < 43);
      rpt  = (k >= 16) && (k < 43) && (((k - 16) % 3) == 0);
      exp  = {held ? 4'b0100 : 4'b0000, (k == 6) ? 4'b0100 : 4'b0000,
              (k == 43) ? 4'b0100 : 4'b0000, rpt ? 4'b0100 : 4'b0000, held};
      exp0 = {held ? 4'b0100 : 4'b0000, (k == 6) ? 4'b0100 : 4'b0000,
              (k == 43) ? 4'b0100 : 4'b0000, 4'b0000, held};
      obs  = {pr, pp, rp, rr, anyp};
      obs0 = {pr0, pp0, rp0, rr0, anyp0};
      n_chk++;
      if (obs !== exp) $display("FAIL repeat k=%0d got %h want %h", k, obs, exp);
      else n_pass++;
      n_chk++;
      if (obs0 !== exp0) $display("FAIL rate0 k=%0d got %h want %h", k, obs0, exp0);
      else n_pass++;
      if (k == 37) btn_n[2] = 1'b1;
    end
  endtask

  task automatic test_reset_mid_press();
    logic [16:0] obs, exp;
    btn_n[0] = 1'b0;
    repeat (7) @(negedge clk);
    n_chk++;
    if (pr !== 4'b0001) $display("FAIL pre_rst_pressed got %b want %b", pr, 4'b0001);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    obs = {pr, pp, rp, rr, anyp};
    n_chk++;
    if (obs !== 17'h0) $display("FAIL rst_mid got %h want %h", obs, 17'h0);
    else n_pass++;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      obs = {pr, pp, rp, rr, anyp};
      exp = {(k >= 6) ? 4'b0001 : 4'b0000, (k == 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, k >= 6};
      n_chk++;
      if (obs !== exp) $display("FAIL post_rst k=%0d got %h want %h", k, obs, exp);
      else n_pass++;
    end
    btn_n = '1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    btn_n = '1;
    test_reset();
    test_press();
    test_bounce();
    test_simultaneous();
    test_repeat();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
